// File: rtl/mem_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_master_pkg
//  Description : Shared definitions for the CPU-to-RAM memory master.
//                Holds the FSM state encoding, the data-path width and the
//                default RAM depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_master_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 512;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

endpackage : mem_master_pkg
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_master
//  Description : Single-outstanding-request memory master. Accepts a CPU
//                load/store (MAR/MDR), range-checks the word address, drives
//                the RAM strobes for WAIT_CYCLES+1 cycles and returns a
//                one-cycle completion pulse (with error flag for bad
//                addresses).
//  Ports       : clock, reset          - clock / synchronous active-high reset
//                req_*                 - CPU request channel (valid/ready)
//                resp_*                - completion pulse, error, load data
//                mem_*                 - RAM strobes, address, data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_master
    import mem_master_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_CYCLES = 1           // legal range 1..15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [DATA_W-1:0] c_depth = DATA_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_wait  = CNT_W'(WAIT_CYCLES);

    // Registered state
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [DATA_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    // Next-state values
    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_write_next;
    logic               w_resp_valid_next;
    logic               w_resp_err_next;
    logic [DATA_W-1:0]  w_resp_rdata_next;
    logic               w_mem_read_next;
    logic               w_mem_write_next;
    logic [DATA_W-1:0]  w_mem_addr_next;
    logic [DATA_W-1:0]  w_mem_wdata_next;

    // ------------------------------------------------------------------------
    // Next-state / output logic. All outputs except req_ready are registered,
    // so each value below is what the output shows in the cycle after the
    // edge on which the FSM moves to w_state_next.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_write_next      = r_write;
        w_resp_valid_next = 1'b0;
        w_resp_err_next   = 1'b0;
        w_resp_rdata_next = r_resp_rdata;
        w_mem_read_next   = 1'b0;
        w_mem_write_next  = 1'b0;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_write_next = req_write;
                    if (req_addr >= c_depth) begin
                        // Bad address: report immediately, RAM untouched.
                        w_state_next      = ERR;
                        w_resp_valid_next = 1'b1;
                        w_resp_err_next   = 1'b1;
                    end else begin
                        w_state_next     = ACCESS;
                        w_cnt_next       = c_wait;
                        w_mem_addr_next  = req_addr;
                        w_mem_wdata_next = req_wdata;
                        w_mem_read_next  = ~req_write;
                        w_mem_write_next = req_write;
                    end
                end
            end

            ACCESS: begin
                if (r_cnt == '0) begin
                    // Last strobe cycle: RAM data is valid on this edge.
                    w_state_next      = RESP;
                    w_resp_valid_next = 1'b1;
                    if (!r_write) begin
                        w_resp_rdata_next = mem_rdata;
                    end
                end else begin
                    // Counter only decrements while non-zero, so it never wraps.
                    w_cnt_next       = r_cnt - 1'b1;
                    w_mem_read_next  = ~r_write;
                    w_mem_write_next = r_write;
                end
            end

            RESP: begin
                w_state_next = IDLE;
            end

            ERR: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_write      <= w_write_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_err   <= w_resp_err_next;
            r_resp_rdata <= w_resp_rdata_next;
            r_mem_read   <= w_mem_read_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule : mem_master
`default_nettype wire

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 The module SHALL have parameter DEPTH, default 512, giving the number of valid word addresses in the attached RAM.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 1, giving the extra cycles the memory strobes are held before read data is captured (range 1..15).
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  1  CPU request present.
REQ-006 Port req_ready  output  1  master idle and able to accept a request.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  word address (MAR value).
REQ-009 Port req_wdata  input  32  store data (MDR value).
REQ-010 Port resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port resp_err  output  1  qualifies resp_valid: address out of range, no access made.
REQ-012 Port resp_rdata  output  32  load data returned to MDR.
REQ-013 Port mem_read  output  1  RAM read strobe.
REQ-014 Port mem_write  output  1  RAM write strobe.
REQ-015 Port mem_addr  output  32  RAM address.
REQ-016 Port mem_wdata  output  32  RAM write data.
REQ-017 Port mem_rdata  input  32  RAM read data (RAMout).

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP, ERR.
REQ-019 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be latched on that edge.
REQ-021 If the latched req_addr is >= DEPTH, the FSM SHALL go IDLE->ERR, assert resp_valid=1 and resp_err=1 for exactly one cycle, never assert mem_read or mem_write, then return to IDLE.
REQ-022 If the address is in range, the FSM SHALL go IDLE->ACCESS and hold mem_addr and mem_wdata at the latched values for WAIT_CYCLES+1 cycles.
REQ-023 During ACCESS, mem_read SHALL equal NOT latched write and mem_write SHALL equal latched write.
REQ-024 mem_read and mem_write SHALL never both be 1, and SHALL both be 0 outside ACCESS.
REQ-025 On the edge that ends ACCESS, a load SHALL register mem_rdata into resp_rdata.
REQ-026 On that edge the FSM SHALL enter RESP with resp_valid=1 and resp_err=0, so resp_valid rises WAIT_CYCLES+1 edges after the accepting edge (edge E2 for default parameters).
REQ-027 A store SHALL leave resp_rdata unchanged.
REQ-028 RESP SHALL last exactly one cycle, then return to IDLE.
REQ-029 There SHALL be no response back-pressure; the consumer must take resp_valid when it is asserted.
REQ-030 A new request SHALL be acceptable on the first IDLE cycle after RESP or ERR, so the minimum spacing between accepts is WAIT_CYCLES+3 edges.
REQ-031 req_valid asserted while req_ready=0 SHALL be ignored and not queued.
REQ-032 The wait counter SHALL be 4 bits wide, loaded on accept and decremented in ACCESS; no wrap-around is permitted.

Reset
REQ-033 reset=1 at a rising edge SHALL force state IDLE and zero the counter.
REQ-034 reset=1 at a rising edge SHALL set resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0 and mem_wdata=0.
REQ-035 req_ready SHALL be 1 on the first cycle after reset is released.
REQ-036 Reset asserted mid-ACCESS SHALL drop the strobes on that edge and produce no response.
REQ-037 Reset SHALL take priority over a simultaneous req_valid.

Structure
REQ-038 A shared package mem_master_pkg SHALL hold the state enumeration, DATA_W=32 and the default MEM_DEPTH=512.
REQ-039 No sub-module is required; the counter and FSM SHALL be implemented inline.

Verification
REQ-040 Store 0x00000055 to address 90, then load address 90 -> mem_write high for 2 cycles; second response resp_rdata=0x00000055 at edge E2 after the load accept.
REQ-041 Load address 133 with RAM preloaded to 16 -> mem_read high 2 cycles, resp_valid pulse with resp_rdata=16, resp_err=0.
REQ-042 Load address 512 -> resp_valid=1 and resp_err=1 one edge after accept, mem_read/mem_write never asserted.
REQ-043 req_valid held high for 10 cycles with loads to addresses 4 and 5 -> accepts exactly WAIT_CYCLES+3=4 edges apart, req_ready low in between.
REQ-044 Reset pulsed during ACCESS of a store to address 175 -> strobes 0 on the next cycle, no resp_valid, RAM address 175 holds its old value if reset precedes the RAM negedge.
REQ-045 WAIT_CYCLES=3 load -> mem_read high 4 cycles, resp_valid rises 4 edges after accept.
